// File: rtl/lsu.sv
// lsu: load/store unit between the core memory stage and a variable-latency
// data memory port. Produces word-aligned, byte-strobed memory transactions
// and returns aligned, sign/zero-extended load data.
//
// Optional feature: define YSYX_24070014_LSU_TIMEOUT_EN to add an 8-bit
// watchdog that ends a stuck transaction with resp_err after TIMEOUT cycles
// in REQ/WAIT. Without the macro the unit waits indefinitely for memory.
//
// state | meaning
// IDLE  | ready for a core request
// REQ   | presenting the memory request, waiting for mem_req_ready
// WAIT  | request accepted by memory, waiting for mem_resp_valid
// DONE  | one-cycle response pulse to the core
module lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("lsu: DATA_W must be 32");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("lsu: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic              req_ready_q,     req_ready_d;
  logic              resp_valid_q,    resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q,    resp_rdata_d;
  logic              resp_err_q,      resp_err_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_we_q,        mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,      mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,     mem_wdata_d;
  logic [3:0]        mem_wstrb_q,     mem_wstrb_d;
  logic [1:0]        size_q,          size_d;
  logic              unsigned_q,      unsigned_d;
  logic [1:0]        addr_lo_q,       addr_lo_d;

  logic              wd_expired;
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
  logic [7:0]        wd_cnt_q,        wd_cnt_d;
`endif

  logic              req_illegal;
  logic [3:0]        strb_base;
  logic [DATA_W-1:0] wdata_masked;
  logic [3:0]        strb_new;
  logic [DATA_W-1:0] wdata_new;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_ext;

  // Decode the incoming request: legality, lane strobes and lane-shifted store data.
  always_comb begin
    req_illegal  = 1'b0;
    strb_base    = 4'b0000;
    wdata_masked = '0;
    case (req_size)
      2'b00: begin
        strb_base    = 4'b0001;
        wdata_masked = {24'b0, req_wdata[7:0]};
      end
      2'b01: begin
        strb_base    = 4'b0011;
        wdata_masked = {16'b0, req_wdata[15:0]};
        req_illegal  = req_addr[0];
      end
      2'b10: begin
        strb_base    = 4'b1111;
        wdata_masked = req_wdata;
        req_illegal  = |req_addr[1:0];
      end
      default: req_illegal = 1'b1;
    endcase
    strb_new  = req_we ? (strb_base << req_addr[1:0]) : 4'b0000;
    wdata_new = req_we ? (wdata_masked << {req_addr[1:0], 3'b000}) : '0;
  end

  // Align the raw read word to the access offset and extend it to 32 bits.
  always_comb begin
    rd_shift = mem_rdata >> {addr_lo_q, 3'b000};
    case (size_q)
      2'b00:   rd_ext = {{24{~unsigned_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = {{16{~unsigned_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Watchdog terminal compare; only meaningful while a transaction is in flight.
  always_comb begin
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
    wd_expired = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                 (wd_cnt_q == 8'(TIMEOUT - 1));
`else
    wd_expired = 1'b0;
`endif
  end

  // Next-state and next-output computation for the request FSM.
  always_comb begin
    state_d         = state_q;
    req_ready_d     = req_ready_q;
    resp_valid_d    = resp_valid_q;
    resp_rdata_d    = resp_rdata_q;
    resp_err_d      = resp_err_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wstrb_d     = mem_wstrb_q;
    size_d          = size_q;
    unsigned_d      = unsigned_q;
    addr_lo_d       = addr_lo_q;
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
    wd_cnt_d        = wd_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        if (req_valid) begin
          req_ready_d = 1'b0;
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          addr_lo_d   = req_addr[1:0];
          if (req_illegal) begin
            // Illegal requests never touch the memory port; answer immediately.
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d         = S_REQ;
            mem_req_valid_d = 1'b1;
            mem_we_d        = req_we;
            mem_addr_d      = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d     = wdata_new;
            mem_wstrb_d     = strb_new;
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
            wd_cnt_d        = 8'd0;
`endif
          end
        end
      end

      S_REQ, S_WAIT: begin
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
        wd_cnt_d = wd_cnt_q + 8'd1;
`endif
        // A response only counts once memory has taken the request; in REQ that
        // means it must coincide with mem_req_ready. A response also beats a
        // watchdog expiry in the same cycle.
        if (mem_resp_valid && ((state_q == S_WAIT) || mem_req_ready)) begin
          state_d         = S_DONE;
          mem_req_valid_d = 1'b0;
          resp_valid_d    = 1'b1;
          resp_err_d      = 1'b0;
          resp_rdata_d    = mem_we_q ? '0 : rd_ext;
        end else if (wd_expired) begin
          state_d         = S_DONE;
          mem_req_valid_d = 1'b0;
          resp_valid_d    = 1'b1;
          resp_err_d      = 1'b1;
          resp_rdata_d    = '0;
        end else if ((state_q == S_REQ) && mem_req_ready) begin
          state_d         = S_WAIT;
          mem_req_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_err_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= 4'b0000;
      size_q          <= 2'b00;
      unsigned_q      <= 1'b0;
      addr_lo_q       <= 2'b00;
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
      wd_cnt_q        <= 8'd0;
`endif
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      size_q          <= size_d;
      unsigned_q      <= unsigned_d;
      addr_lo_q       <= addr_lo_d;
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
      wd_cnt_q        <= wd_cnt_d;
`endif
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu. Built with TIMEOUT = 4 so the watchdog case is
// short when YSYX_24070014_LSU_TIMEOUT_EN is defined.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for IDLE, then presents one request for a single cycle.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL issue_wait_ready req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  // Bounded wait for resp_valid; returns whether seen and how many cycles it took.
  task automatic wait_resp(input int budget, output logic got, output int n);
    got = 1'b0;
    n = 0;
    while (n < budget && !got) begin
      tick();
      n++;
      if (resp_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
    checks++;
    if ({resp_valid, resp_err, mem_req_valid, mem_we, mem_wstrb} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b%b%b%b_%b exp=all 0",
               resp_valid, resp_err, mem_req_valid, mem_we, mem_wstrb);
    end
    checks++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h exp=0", resp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz  [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    logic        un  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  off [9] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [31:0] raw [9] = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234,
                             32'h80FF1234, 32'h80017FFF, 32'h80017FFF, 32'h80017FFF,
                             32'h80017FFF};
    logic [31:0] exp [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF, 32'h00000012,
                             32'h00000034, 32'hFFFF8001, 32'h00008001, 32'h00007FFF,
                             32'h80017FFF};
    logic got;
    int n;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      mem_rdata = raw[i];
      issue(1'b0, sz[i], un[i], {28'h8000000, 2'b00, off[i]}, 32'hFFFFFFFF);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h80000000 || mem_wstrb !== 4'b0000 ||
          mem_we !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL load_req[%0d] valid=%b addr=%h strb=%b we=%b rdy=%b exp 1 80000000 0000 0 0",
                 i, mem_req_valid, mem_addr, mem_wstrb, mem_we, req_ready);
      end
      wait_resp(10, got, n);
      checks++;
      if (!got || n != 1 || resp_rdata !== exp[i] || resp_err !== 1'b0) begin
        failures++;
        $display("FAIL load_resp[%0d] got=%b lat=%0d rdata=%h err=%b exp 1 1 %h 0",
                 i, got, n, resp_rdata, resp_err, exp[i]);
      end
      tick();
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL load_done[%0d] resp_valid=%b req_ready=%b exp 0 1", i, resp_valid, req_ready);
      end
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_store();
    logic [1:0]  sz  [5] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1};
    logic [31:0] ad  [5] = '{32'h80000002, 32'h80000001, 32'h80000008, 32'h80000003, 32'h8000000C};
    logic [31:0] wd  [5] = '{32'h0000ABCD, 32'hDEADBE5A, 32'hCAFEF00D, 32'h00000077, 32'h12345678};
    logic [31:0] ea  [5] = '{32'h80000000, 32'h80000000, 32'h80000008, 32'h80000000, 32'h8000000C};
    logic [31:0] ew  [5] = '{32'hABCD0000, 32'h00005A00, 32'hCAFEF00D, 32'h77000000, 32'h00005678};
    logic [3:0]  es  [5] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000, 4'b0011};
    logic got;
    int n;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, sz[i], 1'b0, ad[i], wd[i]);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ea[i] ||
          mem_wdata !== ew[i] || mem_wstrb !== es[i]) begin
        failures++;
        $display("FAIL store_req[%0d] valid=%b we=%b addr=%h wdata=%h strb=%b exp 1 1 %h %h %b",
                 i, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, ea[i], ew[i], es[i]);
      end
      wait_resp(10, got, n);
      checks++;
      if (!got || n != 1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
        failures++;
        $display("FAIL store_resp[%0d] got=%b lat=%0d rdata=%h err=%b exp 1 1 00000000 0",
                 i, got, n, resp_rdata, resp_err);
      end
      tick();
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic [31:0] ad [4] = '{32'h80000006, 32'h80000001, 32'h80000000, 32'h80000002};
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h5A5A5A5A;
    for (int i = 0; i < 4; i++) begin
      issue(we[i], sz[i], 1'b0, ad[i], 32'h11111111);
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b1 || req_ready !== 1'b0 ||
          mem_req_valid !== 1'b0 || resp_rdata !== 32'h0) begin
        failures++;
        $display("FAIL misaligned_resp[%0d] rv=%b err=%b rdy=%b mrv=%b rdata=%h exp 1 1 0 0 0",
                 i, resp_valid, resp_err, req_ready, mem_req_valid, resp_rdata);
      end
      tick();
      checks++;
      if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL misaligned_after[%0d] rv=%b mrv=%b rdy=%b exp 0 0 1",
                 i, resp_valid, mem_req_valid, req_ready);
      end
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata = 32'h11223344;
    issue(1'b0, 2'd2, 1'b0, 32'h80000010, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h80000010 || req_ready !== 1'b0 ||
          resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] mrv=%b addr=%h rdy=%b rv=%b exp 1 80000010 0 0",
                 i, mem_req_valid, mem_addr, req_ready, resp_valid);
      end
      if (i == 3) mem_req_ready = 1'b1;
      tick();
    end
    mem_req_ready = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_wait1 mrv=%b rv=%b rdy=%b exp 0 0 0", mem_req_valid, resp_valid, req_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_wait2 rv=%b rdy=%b exp 0 0", resp_valid, req_ready);
    end
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h11223344 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_resp rv=%b rdata=%h err=%b rdy=%b exp 1 11223344 0 0",
               resp_valid, resp_rdata, resp_err, req_ready);
    end
    repeat (4) begin
      tick();
      if (resp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_single_pulse extra_pulses=%0d rdy=%b exp 0 1", pulses, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h01020304;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h80000020; req_wdata = 32'h0;
    tick();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h80000020) begin
      failures++;
      $display("FAIL b2b_req1 mrv=%b addr=%h exp 1 80000020", mem_req_valid, mem_addr);
    end
    tick();
    req_size = 2'd0; req_addr = 32'h80000021;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h01020304 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_resp1 rv=%b rdata=%h mrv=%b exp 1 01020304 0", resp_valid, resp_rdata, mem_req_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle rv=%b rdy=%b mrv=%b exp 0 1 0", resp_valid, req_ready, mem_req_valid);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h80000020 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_req2 mrv=%b addr=%h rdy=%b exp 1 80000020 0", mem_req_valid, mem_addr, req_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000003 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_resp2 rv=%b rdata=%h err=%b exp 1 00000003 0", resp_valid, resp_rdata, resp_err);
    end
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int pulses = 0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h80000030, 32'h0);
    tick();
    mem_req_ready = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstw_in_wait mrv=%b rv=%b rdy=%b exp 0 0 0", mem_req_valid, resp_valid, req_ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || {resp_valid, resp_err, mem_req_valid, mem_we, mem_wstrb} !== 8'h00 ||
        {resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      failures++;
      $display("FAIL rstw_cleared rdy=%b rv=%b err=%b mrv=%b addr=%h rdata=%h exp 1 0 0 0 0 0",
               req_ready, resp_valid, resp_err, mem_req_valid, mem_addr, resp_rdata);
    end
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_resp_valid = 1'b0;
    if (resp_valid === 1'b1) pulses++;
    repeat (3) begin
      tick();
      if (resp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rstw_late_resp pulses=%0d rdy=%b rdata=%h exp 0 1 0", pulses, req_ready, resp_rdata);
    end
  endtask

  task automatic test_timeout();
    logic got;
    int n;
    int pulses = 0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
    issue(1'b0, 2'd2, 1'b0, 32'h80000040, 32'h0);
    wait_resp(20, got, n);
    checks++;
    if (!got || n != 4 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire got=%b cycles=%0d err=%b rdata=%h mrv=%b exp 1 4 1 0 0",
               got, n, resp_err, resp_rdata, mem_req_valid);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle rdy=%b rv=%b exp 1 0", req_ready, resp_valid);
    end
    // Response arriving in the same cycle the watchdog would fire must win.
    mem_rdata = 32'h00000055;
    issue(1'b0, 2'd2, 1'b0, 32'h80000044, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    tick();
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h00000055) begin
      failures++;
      $display("FAIL timeout_resp_wins rv=%b err=%b rdata=%h exp 1 0 00000055",
               resp_valid, resp_err, resp_rdata);
    end
    tick();
`else
    mem_rdata = 32'h000000A5;
    mem_req_ready = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h80000040, 32'h0);
    tick();
    mem_req_ready = 1'b0;
    repeat (300) begin
      tick();
      if (resp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_hold pulses=%0d rdy=%b mrv=%b exp 0 0 0", pulses, req_ready, mem_req_valid);
    end
    mem_resp_valid = 1'b1;
    wait_resp(3, got, n);
    mem_resp_valid = 1'b0;
    checks++;
    if (!got || n != 1 || resp_err !== 1'b0 || resp_rdata !== 32'h000000A5) begin
      failures++;
      $display("FAIL no_timeout_late_resp got=%b lat=%0d err=%b rdata=%h exp 1 1 0 000000a5",
               got, n, resp_err, resp_rdata);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store();
    test_misaligned();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the core's memory stage.
- Converts a core memory request (ALU-computed address, rs2 store data, access size/sign) into a word-aligned, byte-strobed transaction on a variable-latency data memory port.
- Returns aligned, sign/zero-extended load data for writeback.
- Replaces the direct combinational top-level memory wiring, so the core can stall on multi-cycle memory.

Parameters:
- ADDR_W, 32, address width (matches ysyx_24070014_ADDR_LEN).
- DATA_W, 32, data width; fixed at 32, any other value is unsupported.
- TIMEOUT, 255, WAIT-state cycle limit; used only with the optional feature.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- req_valid  in  1  Core request valid.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_unsigned  in  1  Zero-extend the load (lbu/lhu).
- req_addr  in  ADDR_W  Byte address.
- req_wdata  in  DATA_W  Store data, right-aligned.
- resp_valid  out  1  One-cycle completion pulse.
- resp_rdata  out  DATA_W  Extended load data; 0 for stores and errors.
- resp_err  out  1  Misaligned access, illegal size, or timeout; valid with resp_valid.
- mem_req_valid  out  1  Memory request valid.
- mem_req_ready  in  1  Memory accepts the request.
- mem_we  out  1  Write enable.
- mem_addr  out  ADDR_W  Word-aligned address: req_addr with bits [1:0] forced to 00.
- mem_wdata  out  DATA_W  Store data shifted to the byte lane.
- mem_wstrb  out  4  Byte strobes; 0000 for loads.
- mem_resp_valid  in  1  Memory completion; read data valid in the same cycle.
- mem_rdata  in  DATA_W  Raw read word.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset drives state to IDLE and all outputs to 0, except req_ready = 1.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we, size, unsigned, addr[1:0], aligned address, shifted wdata and strobes.
  - Illegal request (size = 11, half with addr[0] = 1, or word with addr[1:0] != 00): go to DONE with err = 1. No memory transaction is issued.
  - Legal request: go to REQ.
- REQ:
  - mem_req_valid = 1; mem_we, mem_addr, mem_wdata and mem_wstrb are held stable until the handshake.
  - On mem_req_ready, go to WAIT.
  - If mem_resp_valid arrives in the same cycle as mem_req_ready, capture the data and go directly to DONE.
- WAIT: on mem_resp_valid, capture mem_rdata and go to DONE.
- DONE:
  - resp_valid = 1 for exactly one cycle, then return to IDLE.
  - A new request can be accepted on the following cycle, so minimum latency from accept to resp_valid is 2 cycles (0-wait memory).
- Strobes:
  - Byte: 0001 shifted left by addr[1:0].
  - Half: 0011 shifted left by addr[1:0].
  - Word: 1111.
- Write data: mem_wdata = req_wdata shifted left by 8*addr[1:0]; bytes outside the strobes are don't-care, driven as 0.
- Load data: the raw word is shifted right by 8*addr[1:0], then truncated to the access size and sign- or zero-extended. The result is registered and presented on resp_rdata during DONE.
- Response gating:
  - req_ready = 0 in every state except IDLE.
  - mem_resp_valid in IDLE or REQ (before the handshake) is ignored.
- Reset mid-operation: abort the transaction and return to IDLE with outputs cleared. A late mem_resp_valid from the aborted transaction is ignored.

Optional Feature:
- Macro: YSYX_24070014_LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counter clears on entry to REQ and increments each cycle spent in REQ or WAIT.
  - When the count reaches TIMEOUT, the unit goes to DONE with resp_err = 1 and resp_rdata = 0, and drops mem_req_valid.
  - If mem_resp_valid arrives in the same cycle as the timeout, the response wins: err = 0.
- Not defined: no counter exists; the unit waits indefinitely.

Test Plan:
- Sign/zero extension:
  - lb at 0x80000003 with mem_rdata 0x80FF1234 -> mem_addr 0x80000000, resp_rdata 0xFFFFFF80, err 0.
  - Same access as lbu -> resp_rdata 0x00000080.
- Halfword store: sh at 0x80000002 with wdata 0x0000ABCD -> mem_addr 0x80000000, mem_wdata 0xABCD0000, mem_wstrb 1100, mem_we 1, resp_rdata 0.
- Misaligned word: lw at 0x80000006 -> mem_req_valid never asserted; resp_valid asserted 1 cycle after accept with err 1; req_ready 0 during that cycle.
- Backpressure: mem_req_ready low for 3 cycles, then mem_resp_valid 2 cycles after the handshake -> mem_req_valid and the address stay stable throughout; exactly one resp_valid pulse; req_ready low from accept until DONE.
- Reset in WAIT: assert reset for 1 cycle, then pulse mem_resp_valid -> all outputs 0, req_ready 1, no resp_valid generated.
- Timeout (macro defined, TIMEOUT = 4): memory never responds -> resp_valid with err 1 four cycles after entering REQ. With the macro undefined, the unit remains in WAIT after 300 cycles.
